// File: rtl/ps2_rx_sequencer_if.sv
// PS/2 receiver bus: raw PS/2 lines in, keyboard-buffer write port and status out.
interface ps2_rx_sequencer_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [11:0] ra;
  logic [11:0] wa;
  logic        we;
  logic [7:0]  wr_data;
  logic        rx_err;
  logic [7:0]  drop_cnt;

  modport master (
    output ps2_clk, ps2_data, ra, wa,
    input  we, wr_data, rx_err, drop_cnt
  );

  modport slave (
    input  ps2_clk, ps2_data, ra, wa,
    output we, wr_data, rx_err, drop_cnt
  );
endinterface

// File: rtl/ps2_rx_sequencer.sv
// PS/2 frame receiver that writes scan codes into a circular keyboard buffer.
// Optional macro PS2_PARITY_CHECK_EN rejects frames with bad odd parity.
module ps2_rx_sequencer #(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic              wr_clk,
  input  logic              reset,
  ps2_rx_sequencer_if.slave bus
);

  localparam int          FCW     = $clog2(FILTER_LEN + 1);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, EMIT} state_t;

  state_t         state, state_d;
  logic           clk_p0, clk_p1, data_p0, data_p1;
  logic           filt, fall;
  logic [FCW-1:0] fcnt;
  logic [7:0]     shift;
  logic [2:0]     bit_cnt;
  logic [15:0]    to_cnt;
  logic [7:0]     hold;
  logic           rx_err;
  logic [7:0]     drop_cnt;
  logic           frame_err;
  logic           par_bad;
  logic           full;

  // Stage p0/p1: two-flop synchronizers; lines idle high
  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      clk_p0  <= 1'b1;
      clk_p1  <= 1'b1;
      data_p0 <= 1'b1;
      data_p1 <= 1'b1;
    end else begin
      clk_p0  <= bus.ps2_clk;
      clk_p1  <= clk_p0;
      data_p0 <= bus.ps2_data;
      data_p1 <= data_p0;
    end
  end

  // Filter stage: level follows clk_p1 only after FILTER_LEN agreeing samples
  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      filt <= 1'b1;
      fcnt <= '0;
      fall <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_p1 == filt) begin
        fcnt <= '0;
      end else if (fcnt == FCW'(FILTER_LEN - 1)) begin
        filt <= clk_p1;
        fcnt <= '0;
        fall <= filt;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic par;

  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset)
      par <= 1'b0;
    else if (state == PARITY && fall)
      par <= data_p1;
  end

  // Odd parity over data plus parity bit; even weight is an error
  assign par_bad = ~^{shift, par};
`else
  assign par_bad = 1'b0;
`endif

  assign full = (bus.wa + 12'd1) == bus.ra;

  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_d;
  end

  always_comb begin
    state_d   = state;
    frame_err = 1'b0;
    case (state)
      IDLE:   if (fall && !data_p1) state_d = DATA;
      DATA:   if (fall && bit_cnt == 3'd7) state_d = PARITY;
      PARITY: if (fall) state_d = STOP;
      STOP: begin
        if (fall) begin
          if (!data_p1 || par_bad) begin
            state_d   = IDLE;
            frame_err = 1'b1;
          end else begin
            state_d = EMIT;
          end
        end
      end
      EMIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A falling edge in the same cycle always beats the timeout
    if ((state inside {DATA, PARITY, STOP}) && !fall && to_cnt == TO_LAST) begin
      state_d   = IDLE;
      frame_err = 1'b1;
    end
  end

  // Frame stage: shifter, timeout, status counters
  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      shift    <= '0;
      bit_cnt  <= '0;
      to_cnt   <= '0;
      hold     <= '0;
      rx_err   <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (state == IDLE || fall)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + 1'b1;

      if (state == IDLE && fall && !data_p1)
        bit_cnt <= '0;
      else if (state == DATA && fall) begin
        shift   <= {data_p1, shift[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (frame_err)
        rx_err <= 1'b1;

      if (state == EMIT) begin
        if (full) begin
          if (drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 1'b1;
        end else begin
          hold <= shift;
        end
      end
    end
  end

  assign bus.we       = (state == EMIT) && !full;
  assign bus.wr_data  = bus.we ? shift : hold;
  assign bus.rx_err   = rx_err;
  assign bus.drop_cnt = drop_cnt;

endmodule

// File: doc/ps2_rx_sequencer.md
PS2_RX_SEQUENCER -- requirements
Module: ps2_rx_sequencer

Interface
REQ-001 Parameter FILTER_LEN, default 4: consecutive identical synchronized ps2_clk samples required before the filtered clock changes level.
REQ-002 Parameter TIMEOUT_CYC, default 50000: wr_clk cycles without a filtered falling edge mid-frame before the frame is aborted; 16-bit counter.
REQ-003 reset  in  1  asynchronous, active-high; clock is wr_clk.
REQ-004 wr_clk  in  1  system clock; same clock as the keyboard buffer write port.
REQ-005 ps2_clk  in  1  raw PS/2 clock line, asynchronous to wr_clk.
REQ-006 ps2_data  in  1  raw PS/2 data line, asynchronous to wr_clk.
REQ-007 ra  in  12  buffer read address.
REQ-008 wa  in  12  buffer write address.
REQ-009 we  out  1  single-cycle buffer write strobe.
REQ-010 wr_data  out  8  scan code presented with we.
REQ-011 rx_err  out  1  sticky frame error flag (timeout, framing or parity).
REQ-012 drop_cnt  out  8  saturating count of codes dropped because the buffer was full.

Function
REQ-013 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer on wr_clk before any use.
REQ-014 The filtered clock SHALL change level only after FILTER_LEN consecutive equal synchronized samples; a falling edge is a filtered 1->0 transition, flagged for exactly one cycle.
REQ-015 Data SHALL be sampled from synchronized ps2_data in the cycle the falling edge is flagged.
REQ-016 FSM states: IDLE, DATA, PARITY, STOP, EMIT.
REQ-017 IDLE: on falling edge with data=0 -> DATA and bit counter cleared; data=1 -> stay IDLE with no error.
REQ-018 DATA: shift 8 bits LSB first; after the 8th bit -> PARITY.
REQ-019 PARITY: capture the parity bit -> STOP.
REQ-020 STOP: data=1 -> EMIT; data=0 -> IDLE, set rx_err, no write.
REQ-021 EMIT: lasts one cycle, then -> IDLE.
REQ-022 In EMIT, buffer full SHALL be defined as (wa + 1) mod 4096 == ra, compared at 12 bits.
REQ-023 In EMIT when not full: we=1 for exactly that cycle with wr_data equal to the received byte.
REQ-024 In EMIT when full: we stays 0 and drop_cnt increments, saturating at 255.
REQ-025 wr_data SHALL hold its last value between writes; we is never high outside EMIT.
REQ-026 In DATA, PARITY or STOP, TIMEOUT_CYC cycles without a falling edge -> IDLE and set rx_err; the timeout counter clears on every falling edge and in IDLE.
REQ-027 If a timeout expires in the same cycle as a falling edge, the edge SHALL win.
REQ-028 Latency: we SHALL assert 1 wr_clk cycle after the cycle in which the stop-bit edge is flagged.
REQ-029 rx_err and drop_cnt SHALL clear only on reset.

Reset
REQ-030 Reset SHALL immediately force: FSM IDLE, we=0, wr_data=0, rx_err=0, drop_cnt=0, synchronizers and filter=1, counters=0.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame; no write occurs after release until a complete new frame is received.

Configuration
REQ-032 Macro PS2_PARITY_CHECK_EN defined: in STOP, if the 9 bits (8 data + parity) have even weight, -> IDLE, set rx_err, no write.
REQ-033 Macro PS2_PARITY_CHECK_EN undefined: the parity bit is captured but ignored; every frame with a valid stop bit is emitted.

Verification
REQ-034 Frame 0x1C with correct parity 0, stop 1, ra=wa=0 -> one we pulse, wr_data=0x1C, rx_err=0.
REQ-035 Frame 0x1C with parity 1 -> with PS2_PARITY_CHECK_EN: no we, rx_err=1; without the macro: we pulse with 0x1C.
REQ-036 wa=0xFFF, ra=0x000, frame 0xF0 -> no we, drop_cnt=1; repeat 300 frames -> drop_cnt=255.
REQ-037 Start bit plus 3 data bits, then ps2_clk held high for 50000 cycles -> rx_err=1 and FSM IDLE; next valid frame 0x5A -> we with 0x5A.
REQ-038 A 2-cycle low glitch on ps2_clk while idle -> no falling edge flagged, no state change.
REQ-039 Reset asserted after the 5th data bit of a frame, then released -> all outputs 0, and the trailing bits of the aborted frame produce no we.
